// File: rtl/bubble_out_sequencer.sv
// Bubble data output sequencer: position counter, boot/page frame FSM and buffered data path.
// Optional BUBBLE_UNDERRUN_DETECT_EN adds buf_ready/underrun buffer starvation detection.

module bubble_out_sequencer #(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned N_POS      = 2053,
  parameter int unsigned POS_INIT   = 1464,
  parameter int unsigned BOOT_PRE   = 2640,
  parameter logic [7:0]  BOOT_SYNC  = 8'b0000_0111,
  parameter int unsigned BOOT_DATA  = 1920,
  parameter int unsigned BOOT_DUMMY = 6,
  parameter int unsigned BOOT_TAIL  = 3,
  parameter int unsigned PAGE_LEAD  = 100,
  parameter int unsigned PAGE_DATA  = 512,
  parameter int unsigned PAGE_TAIL  = 91
) (
  input  logic              master_clock,
  input  logic              reset,
  input  logic              bubble_module_enable,
  input  logic              position_change,
  input  logic              data_out_strobe,
  input  logic              position_latch,
  input  logic              page_select,
  input  logic              coil_run,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [N_CH-1:0]   wr_data,
`ifdef BUBBLE_UNDERRUN_DETECT_EN
  input  logic              buf_ready,
  output logic              underrun,
`endif
  output logic [11:0]       bubble_position,
  output logic              convert,
  output logic              load_bootloader,
  output logic              load_page,
  output logic [12:0]       bit_count,
  output logic [N_CH-1:0]   bubble_out
);

  localparam logic [12:0] BootPreHi   = 13'(BOOT_PRE);
  localparam logic [12:0] BootSyncA   = 13'(BOOT_PRE + 1);
  localparam logic [12:0] BootSyncB   = 13'(BOOT_PRE + 2);
  localparam logic [12:0] BootDataLo  = 13'(BOOT_PRE + 3);
  localparam logic [12:0] BootDataHi  = 13'(BOOT_PRE + 2 + BOOT_DATA);
  localparam logic [12:0] BootDummyHi = 13'(BOOT_PRE + 2 + BOOT_DATA + BOOT_DUMMY);
  localparam logic [12:0] BootTotal   = 13'(BOOT_PRE + 2 + BOOT_DATA + BOOT_DUMMY + BOOT_TAIL);
  localparam logic [12:0] PageDataLo  = 13'(PAGE_LEAD + 1);
  localparam logic [12:0] PageDataHi  = 13'(PAGE_LEAD + PAGE_DATA);
  localparam logic [12:0] PageTotal   = 13'(PAGE_LEAD + PAGE_DATA + PAGE_TAIL);
  localparam logic [11:0] PosLast     = 12'(N_POS - 1);
  // Sync is sent upper half first; each half carries one bit per channel.
  localparam logic [N_CH-1:0] SyncStep0 = BOOT_SYNC[N_CH +: N_CH];
  localparam logic [N_CH-1:0] SyncStep1 = BOOT_SYNC[0 +: N_CH];

  typedef enum logic [1:0] {StIdle, StBoot, StPage, StHold} state_e;

  state_e              state_q, state_d;
  logic                boot_mode_q, boot_mode_d;
  logic                pos_chg_q, strobe_q;
  logic [11:0]         pos_q, pos_d;
  logic [12:0]         bit_count_q, bit_count_d, bit_count_inc;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [N_CH-1:0]     data_q, data_bits, out_q, out_d;
  logic                load_boot_q, load_page_q;
  logic [N_CH-1:0]     mem_q [2**ADDR_W];
  logic                pos_rise, strobe_rise, strobe_fall, in_frame, in_window, rd_fire;
  logic [12:0]         frame_total, win_lo, win_hi;
  logic                starved;

  assign pos_rise      = position_change & ~pos_chg_q;
  assign strobe_rise   = data_out_strobe & ~strobe_q;
  assign strobe_fall   = ~data_out_strobe & strobe_q;
  assign in_frame      = (state_q == StBoot) || (state_q == StPage);
  assign frame_total   = (state_q == StBoot) ? BootTotal : PageTotal;
  assign win_lo        = (state_q == StBoot) ? BootDataLo : PageDataLo;
  assign win_hi        = (state_q == StBoot) ? BootDataHi : PageDataHi;
  assign bit_count_inc = bit_count_q + 13'd1;
  assign in_window     = (bit_count_inc >= win_lo) && (bit_count_inc <= win_hi);
  assign rd_fire       = in_frame & strobe_rise & in_window;
  assign pos_d         = !pos_rise ? pos_q : (pos_q == PosLast) ? 12'd0 : pos_q + 12'd1;

  always_comb begin
    state_d     = state_q;
    boot_mode_d = boot_mode_q;
    bit_count_d = bit_count_q;
    rd_addr_d   = rd_addr_q;
    if (!coil_run) begin
      state_d     = StIdle;
      bit_count_d = '0;
      rd_addr_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!page_select || position_latch) begin
            state_d     = page_select ? StPage : StBoot;
            boot_mode_d = ~page_select;
            bit_count_d = '0;
            rd_addr_d   = '0;
          end
        end
        StBoot, StPage: begin
          if (strobe_fall && (bit_count_q != frame_total)) bit_count_d = bit_count_inc;
          if (rd_fire) rd_addr_d = rd_addr_q + 1'b1;
          if (bit_count_d == frame_total) state_d = StHold;
        end
        default: ;
      endcase
    end
  end

`ifdef BUBBLE_UNDERRUN_DETECT_EN
  logic underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if ((state_d == StIdle) && (state_q != StIdle)) begin
      underrun_d = 1'b0;
    end else if (rd_fire && (rd_addr_q == '0) && (bit_count_inc == win_lo) && !buf_ready) begin
      underrun_d = 1'b1;
    end
  end

  assign starved  = underrun_q;
  assign underrun = underrun_q;
`else
  assign starved = 1'b0;
`endif

  always_comb begin
    data_bits = starved ? '1 : ~data_q;
    out_d     = '1;
    if (bubble_module_enable) begin
      out_d = '0;
    end else if (bit_count_d == '0) begin
      out_d = '1;
    end else if (state_d == StBoot) begin
      if (bit_count_d <= BootPreHi)        out_d = '1;
      else if (bit_count_d == BootSyncA)   out_d = ~SyncStep0;
      else if (bit_count_d == BootSyncB)   out_d = ~SyncStep1;
      else if (bit_count_d <= BootDataHi)  out_d = data_bits;
      else if (bit_count_d <= BootDummyHi) out_d = '0;
    end else if (state_d == StPage) begin
      if ((bit_count_d >= PageDataLo) && (bit_count_d <= PageDataHi)) out_d = data_bits;
    end
  end

  // Buffer: read-before-write gives old data on a same-address collision.
  always_ff @(posedge master_clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_fire) data_q <= mem_q[rd_addr_q];
  end

  always_ff @(posedge master_clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      boot_mode_q <= 1'b0;
      pos_chg_q   <= 1'b0;
      strobe_q    <= 1'b0;
      pos_q       <= 12'(POS_INIT);
      bit_count_q <= '0;
      rd_addr_q   <= '0;
      out_q       <= '1;
      load_boot_q <= 1'b1;
      load_page_q <= 1'b1;
`ifdef BUBBLE_UNDERRUN_DETECT_EN
      underrun_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      boot_mode_q <= boot_mode_d;
      pos_chg_q   <= position_change;
      strobe_q    <= data_out_strobe;
      pos_q       <= pos_d;
      bit_count_q <= bit_count_d;
      rd_addr_q   <= rd_addr_d;
      out_q       <= out_d;
      load_boot_q <= ~((state_d == StBoot) || ((state_d == StHold) && boot_mode_d));
      load_page_q <= ~((state_d == StPage) || ((state_d == StHold) && !boot_mode_d));
`ifdef BUBBLE_UNDERRUN_DETECT_EN
      underrun_q  <= underrun_d;
`endif
    end
  end

  assign bubble_position = pos_q;
  assign convert         = position_latch & page_select;
  assign load_bootloader = load_boot_q;
  assign load_page       = load_page_q;
  assign bit_count       = bit_count_q;
  assign bubble_out      = out_q;

endmodule

// File: tb/tb_bubble_out_sequencer.sv
// Scoreboard bench for bubble_out_sequencer: randomized strobe timing, buffer data and enable
// windows checked against a bit-index reference model of the frame layout.

module tb_bubble_out_sequencer;

  logic        master_clock = 1'b0;
  logic        reset, bubble_module_enable, position_change, data_out_strobe;
  logic        position_latch, page_select, coil_run, wr_en;
  logic [10:0] wr_addr;
  logic [1:0]  wr_data;
  logic [11:0] bubble_position;
  logic        convert, load_bootloader, load_page;
  logic [12:0] bit_count;
  logic [1:0]  bubble_out;
`ifdef BUBBLE_UNDERRUN_DETECT_EN
  logic        buf_ready, underrun;
`endif

  always #5 master_clock = ~master_clock;

  bubble_out_sequencer dut (
    .master_clock         (master_clock),
    .reset                (reset),
    .bubble_module_enable (bubble_module_enable),
    .position_change      (position_change),
    .data_out_strobe      (data_out_strobe),
    .position_latch       (position_latch),
    .page_select          (page_select),
    .coil_run             (coil_run),
    .wr_en                (wr_en),
    .wr_addr              (wr_addr),
    .wr_data              (wr_data),
`ifdef BUBBLE_UNDERRUN_DETECT_EN
    .buf_ready            (buf_ready),
    .underrun             (underrun),
`endif
    .bubble_position      (bubble_position),
    .convert              (convert),
    .load_bootloader      (load_bootloader),
    .load_page            (load_page),
    .bit_count            (bit_count),
    .bubble_out           (bubble_out)
  );

  int          total = 0;
  int          bad   = 0;
  int          exp_bc_q[$];
  logic [1:0]  exp_out_q[$];
  logic [1:0]  ref_mem [2048];
  bit          mon_en = 1'b0;
  logic [12:0] last_bc;
  int          mon_bc;
  logic [1:0]  mon_out;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Expected pin value for frame bit b, derived from the frame layout by bit index.
  function automatic logic [1:0] model_out(input bit boot, input int b, input bit dis,
                                           input bit starve);
    if (dis) return 2'b00;
    if (b == 0) return 2'b11;
    if (boot) begin
      if (b <= 2640) return 2'b11;
      if (b == 2641) return 2'b10;
      if (b == 2642) return 2'b00;
      if (b <= 4562) return ~ref_mem[b - 2643];
      if (b <= 4568) return 2'b00;
      return 2'b11;
    end
    if (b >= 101 && b <= 612) return starve ? 2'b11 : ~ref_mem[b - 101];
    return 2'b11;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge master_clock);
  endtask

  task automatic write_word(input int addr, input logic [1:0] data);
    wr_en   = 1'b1;
    wr_addr = 11'(addr);
    wr_data = data;
    ref_mem[addr] = data;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic raw_strobe();
    data_out_strobe = 1'b1;
    tick($urandom_range(1, 3));
    data_out_strobe = 1'b0;
    tick($urandom_range(1, 3));
  endtask

  task automatic strobe_bit(input bit boot, input int b, input bit dis, input bit starve);
    bubble_module_enable = dis;
    exp_bc_q.push_back(b);
    exp_out_q.push_back(model_out(boot, b, dis, starve));
    raw_strobe();
  endtask

  task automatic abort_frame();
    exp_bc_q.push_back(0);
    exp_out_q.push_back(2'b11);
    coil_run = 1'b0;
    tick(2);
  endtask

  // Monitor: every new bit_count presented by the DUT consumes one scoreboard entry.
  initial begin
    last_bc = '0;
    forever begin
      @(negedge master_clock);
      if (mon_en && (bit_count !== last_bc)) begin
        if (exp_bc_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_bit: got bit_count %0d, expected no change from %0d",
                   bit_count, last_bc);
        end else begin
          mon_bc  = exp_bc_q.pop_front();
          mon_out = exp_out_q.pop_front();
          check("bit_count", 32'(bit_count), 32'(mon_bc));
          check($sformatf("bubble_out@%0d", mon_bc), 32'(bubble_out), 32'(mon_out));
        end
      end
      last_bc = bit_count;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dis_lo, dis_hi;
    reset = 1'b1; bubble_module_enable = 1'b0; position_change = 1'b0; data_out_strobe = 1'b0;
    position_latch = 1'b0; page_select = 1'b0; coil_run = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0;
`ifdef BUBBLE_UNDERRUN_DETECT_EN
    buf_ready = 1'b1;
`endif
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_position", 32'(bubble_position), 32'd1464);
    check("rst_load_bootloader", 32'(load_bootloader), 32'd1);
    check("rst_load_page", 32'(load_page), 32'd1);
    check("rst_bit_count", 32'(bit_count), 32'd0);
    check("rst_bubble_out", 32'(bubble_out), 32'd3);
    check("rst_convert", 32'(convert), 32'd0);
`ifdef BUBBLE_UNDERRUN_DETECT_EN
    check("rst_underrun", 32'(underrun), 32'd0);
`endif
    mon_en = 1'b1;

    for (int i = 1; i <= 2053; i++) begin
      position_change = 1'b1;
      tick($urandom_range(1, 2));
      position_change = 1'b0;
      tick($urandom_range(1, 2));
      if (i == 588) check("pos_top", 32'(bubble_position), 32'd2052);
      if (i == 589) check("pos_wrap", 32'(bubble_position), 32'd0);
    end
    check("pos_full_loop", 32'(bubble_position), 32'd1464);

    // Boot frame with word[i] = i[1:0].
    for (int i = 0; i < 2048; i++) write_word(i, 2'(i));
    page_select = 1'b0;
    coil_run    = 1'b1;
    tick(2);
    check("boot_load_bootloader", 32'(load_bootloader), 32'd0);
    check("boot_load_page", 32'(load_page), 32'd1);
    check("boot_start_out", 32'(bubble_out), 32'd3);
    for (int b = 1; b <= 4571; b++) strobe_bit(1'b1, b, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) raw_strobe();
    check("boot_saturate", 32'(bit_count), 32'd4571);
    check("boot_hold_out", 32'(bubble_out), 32'd3);
    check("boot_hold_load", 32'(load_bootloader), 32'd0);
    abort_frame();
    check("boot_end_load", 32'(load_bootloader), 32'd1);

    // Page frame with random data and a random module-disable window.
    for (int i = 0; i < 512; i++) write_word(i, 2'($urandom_range(0, 3)));
    dis_lo = $urandom_range(150, 550);
    dis_hi = dis_lo + $urandom_range(5, 40);
    page_select    = 1'b1;
    position_latch = 1'b1;
    coil_run       = 1'b1;
    tick(1);
    check("page_convert", 32'(convert), 32'd1);
    tick(1);
    check("page_load_page", 32'(load_page), 32'd0);
    check("page_load_boot", 32'(load_bootloader), 32'd1);
    position_latch = 1'b0;
    for (int b = 1; b <= 703; b++) strobe_bit(1'b0, b, (b >= dis_lo) && (b <= dis_hi), 1'b0);
    bubble_module_enable = 1'b0;
    raw_strobe();
    check("page_saturate", 32'(bit_count), 32'd703);
    check("page_hold_load", 32'(load_page), 32'd0);
    abort_frame();
    check("page_end_load", 32'(load_page), 32'd1);

    // Boot frame aborted at bit 3000, coil_run falling together with the strobe.
    page_select = 1'b0;
    coil_run    = 1'b1;
    tick(2);
    for (int b = 1; b <= 3000; b++) strobe_bit(1'b1, b, 1'b0, 1'b0);
    data_out_strobe = 1'b1;
    tick(2);
    exp_bc_q.push_back(0);
    exp_out_q.push_back(2'b11);
    data_out_strobe = 1'b0;
    coil_run        = 1'b0;
    tick(1);
    check("abort_load_boot", 32'(load_bootloader), 32'd1);
    check("abort_bit_count", 32'(bit_count), 32'd0);
    check("abort_out", 32'(bubble_out), 32'd3);
    tick(1);

`ifdef BUBBLE_UNDERRUN_DETECT_EN
    buf_ready      = 1'b0;
    page_select    = 1'b1;
    position_latch = 1'b1;
    coil_run       = 1'b1;
    tick(2);
    position_latch = 1'b0;
    for (int b = 1; b <= 703; b++) strobe_bit(1'b0, b, 1'b0, 1'b1);
    check("underrun_set", 32'(underrun), 32'd1);
    abort_frame();
    check("underrun_clear", 32'(underrun), 32'd0);
    buf_ready = 1'b1;
`endif

    tick(2);
    check("scoreboard_drained", 32'(exp_bc_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
